// File: rtl/eh2_exu_mul_pipe.sv
// ---------------------------------------------------------------------------
// eh2_exu_mul_pipe
//
// Pipelined integer multiplier for the execute unit. It supports the
// MUL/MULH/MULHSU/MULHU family: each operand is optionally treated as signed,
// and either the low or the high half of the 2*WIDTH product is returned.
// The issue-to-result latency is STAGES cycles, and the pipe accepts one op
// per cycle.
//
// Pipeline:
//   S1 : captures the raw operands, controls and bypass selects.
//   S2 : holds the bypass-resolved, sign-extended (WIDTH+1)-bit operands.
//   S3 : holds the 2*WIDTH product (STAGES >= 3 only).
//   S4 : is a pure delay of the product (STAGES == 4 only).
// When STAGES == 2, the product and the half select come combinationally
// from S2.
//
// Ports:
//   clk, rst_l          clock; synchronous active-low reset
//   in_valid            a new op is issued this cycle
//   in_a, in_b          rs1 / rs2 operands
//   in_rs1_sign/rs2     treat the corresponding operand as signed
//   in_low              1 = low half (MUL), 0 = high half (MULH*)
//   in_tag              destination tag carried with the op
//   in_byp_a/b          replace the operand with byp_data while the op is in S1
//   byp_data            late load-result bypass data
//   stall               freezes the whole pipe
//   flush               kills every op in flight plus any op issued this cycle
//   out_valid           a result is presented this cycle
//   out_result/out_tag  result half and its tag (both zero when idle)
//   busy                at least one stage holds a valid op
// ---------------------------------------------------------------------------
module eh2_exu_mul_pipe #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 3,
   parameter int TAG_W  = 5
) (
   input  logic             clk,
   input  logic             rst_l,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_rs1_sign,
   input  logic             in_rs2_sign,
   input  logic             in_low,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             in_byp_a,
   input  logic             in_byp_b,
   input  logic [WIDTH-1:0] byp_data,
   input  logic             stall,
   input  logic             flush,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_result,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);

   localparam int XW = WIDTH + 1;   // extended operand width
   localparam int PW = 2 * WIDTH;   // kept product width

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             rs1_sign;
      logic             rs2_sign;
      logic             low;
      logic [TAG_W-1:0] tag;
      logic             byp_a;
      logic             byp_b;
   } s1_t;

   typedef struct packed {
      logic [XW-1:0]    a;
      logic [XW-1:0]    b;
      logic             low;
      logic [TAG_W-1:0] tag;
   } s2_t;

   logic [STAGES:1]      vld_d, vld_q;     // bit k = stage Sk holds a live op
   s1_t                  s1_d, s1_q;
   s2_t                  s2_d, s2_q;

   logic [WIDTH-1:0]     op_a, op_b;
   logic [XW-1:0]        ext_a, ext_b;
   logic signed [PW-1:0] mul_a, mul_b;
   logic [PW-1:0]        mul_prod;

   logic [PW-1:0]        last_prod;
   logic                 last_low;
   logic [TAG_W-1:0]     last_tag;

   // Stage-1 operand resolution and the stage-2 multiply.
   always_comb begin
      op_a  = s1_q.byp_a ? byp_data : s1_q.a;
      op_b  = s1_q.byp_b ? byp_data : s1_q.b;
      ext_a = {s1_q.rs1_sign & op_a[WIDTH-1], op_a};
      ext_b = {s1_q.rs2_sign & op_b[WIDTH-1], op_b};
      // Sign-extending both operands to PW bits makes a PW x PW product
      // truncated to PW bits equal to the truncated (XW x XW) signed product.
      mul_a    = {{(WIDTH-1){s2_q.a[XW-1]}}, s2_q.a};
      mul_b    = {{(WIDTH-1){s2_q.b[XW-1]}}, s2_q.b};
      mul_prod = mul_a * mul_b;
   end

   // Valid chain and the S1/S2 data registers.
   always_comb begin
      // NOTE: every signal driven here gets a default first; otherwise a path
      // that skips its assignment would make synthesis infer a latch.
      vld_d = vld_q;
      s1_d  = s1_q;
      s2_d  = s2_q;

      if (flush) begin
         vld_d = '0;
      end else if (!stall) begin
         vld_d = {vld_q[STAGES-1:1], in_valid};
      end

      if (in_valid && !stall && !flush) begin
         s1_d.a        = in_a;
         s1_d.b        = in_b;
         s1_d.rs1_sign = in_rs1_sign;
         s1_d.rs2_sign = in_rs2_sign;
         s1_d.low      = in_low;
         s1_d.tag      = in_tag;
         s1_d.byp_a    = in_byp_a;
         s1_d.byp_b    = in_byp_b;
      end

      if (vld_q[1] && !stall) begin
         s2_d.a   = ext_a;
         s2_d.b   = ext_b;
         s2_d.low = s1_q.low;
         s2_d.tag = s1_q.tag;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments, so every flop
      // samples the values from before the edge and the update order does
      // not matter.
      if (!rst_l) begin
         vld_q <= '0;
      end else begin
         vld_q <= vld_d;
      end
   end

   // NOTE: the data registers are deliberately left without a reset. Only the
   // valid bits decide whether their contents are used, and the outputs are
   // forced to zero when no op is valid.
   always_ff @(posedge clk) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
   end

   if (STAGES == 2) begin : g_comb_out
      always_comb begin
         last_prod = mul_prod;
         last_low  = s2_q.low;
         last_tag  = s2_q.tag;
      end
   end else begin : g_prod_pipe
      typedef struct packed {
         logic [PW-1:0]    prod;
         logic             low;
         logic [TAG_W-1:0] tag;
      } sp_t;

      sp_t sp_d [3:STAGES];
      sp_t sp_q [3:STAGES];

      for (genvar k = 3; k <= STAGES; k++) begin : g_stage
         if (k == 3) begin : g_mul
            always_comb begin
               sp_d[k] = sp_q[k];
               if (vld_q[k-1] && !stall) begin
                  sp_d[k].prod = mul_prod;
                  sp_d[k].low  = s2_q.low;
                  sp_d[k].tag  = s2_q.tag;
               end
            end
         end else begin : g_dly
            always_comb begin
               sp_d[k] = sp_q[k];
               if (vld_q[k-1] && !stall) begin
                  sp_d[k] = sp_q[k-1];
               end
            end
         end

         always_ff @(posedge clk) begin
            sp_q[k] <= sp_d[k];
         end
      end

      always_comb begin
         last_prod = sp_q[STAGES].prod;
         last_low  = sp_q[STAGES].low;
         last_tag  = sp_q[STAGES].tag;
      end
   end

   // The outputs are gated by the last valid bit so they read as zero when idle.
   always_comb begin
      out_valid  = vld_q[STAGES];
      out_result = '0;
      out_tag    = '0;
      if (out_valid) begin
         out_result = last_low ? last_prod[WIDTH-1:0] : last_prod[PW-1:WIDTH];
         out_tag    = last_tag;
      end
      busy = |vld_q;
   end

endmodule

// File: doc/eh2_exu_mul_pipe.md
EH2_EXU_MUL_PIPE -- requirements
Module: eh2_exu_mul_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; legal values 32 and 64.
REQ-002 SHALL have parameter STAGES, default 3, issue-to-result latency in cycles; legal values 2 to 4.
REQ-003 SHALL have parameter TAG_W, default 5, width of the destination tag carried with each op.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_l  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  new multiply op issued this cycle.
REQ-007 in_a, in_b  input  WIDTH each  rs1 and rs2 operands.
REQ-008 in_rs1_sign, in_rs2_sign  input  1 each  treat operand as signed.
REQ-009 in_low  input  1  1 = return low half (MUL); 0 = return high half (MULH/MULHSU/MULHU).
REQ-010 in_tag  input  TAG_W  destination tag.
REQ-011 in_byp_a, in_byp_b  input  1 each  replace the captured operand with byp_data in stage 1.
REQ-012 byp_data  input  WIDTH  late load-result bypass data, sampled in stage 1.
REQ-013 stall  input  1  freeze the whole pipeline.
REQ-014 flush  input  1  kill every op in flight and any op issued this cycle.
REQ-015 out_valid  output  1  result valid.
REQ-016 out_result  output  WIDTH  selected product half.
REQ-017 out_tag  output  TAG_W  tag of the op being returned.
REQ-018 busy  output  1  OR of all stage valid bits.

Function
REQ-019 SHALL implement STAGES pipeline registers S1..S(STAGES), each with its own valid bit; throughput one op per cycle.
REQ-020 S1 SHALL capture in_a, in_b, both sign bits, in_low, in_tag and both bypass selects when in_valid=1, stall=0 and flush=0.
REQ-021 In S1, operand A SHALL be byp_data when the captured in_byp_a=1, else the captured in_a; operand B likewise with in_byp_b.
REQ-022 Each operand SHALL be extended to WIDTH+1 bits, MSB = sign flag AND operand[WIDTH-1]; the product SHALL be the signed (WIDTH+1)x(WIDTH+1) product truncated to 2*WIDTH bits.
REQ-023 The bypass-resolved extended operands SHALL be registered into S2; the product SHALL be formed from S2 and registered into S3; further stages SHALL only delay the product. When STAGES=2, the product SHALL be computed combinationally from S2 and the half select applied combinationally.
REQ-024 out_result SHALL be product[WIDTH-1:0] when the op's low bit is 1, else product[2*WIDTH-1:WIDTH].
REQ-025 Latency: with no stall and no flush, in_valid at cycle N SHALL give out_valid=1 at cycle N+STAGES with the matching out_tag.
REQ-026 stall=1 SHALL hold every valid, data and tag register; in_valid SHALL be ignored during stall, and upstream re-presents the op.
REQ-027 While stall=1 and the last stage holds a valid op, out_valid, out_result and out_tag SHALL stay asserted and constant.
REQ-028 flush=1 SHALL clear all valid bits on the next edge; flush SHALL take priority over stall and in_valid.
REQ-029 Data registers of a stage SHALL update only when the preceding stage's valid is 1 and stall=0.
REQ-030 out_result and out_tag SHALL be 0 whenever out_valid=0.
REQ-031 Ops in flight SHALL retire in issue order; they SHALL NOT be reordered or merged.

Reset
REQ-032 rst_l=0 at a clock edge SHALL clear all valid bits; out_valid=0, out_result=0, out_tag=0 and busy=0 from the following cycle.
REQ-033 Reset SHALL take priority over flush, stall and in_valid, and SHALL discard ops in flight; data registers need not be cleared.
REQ-034 The first op SHALL be accepted in the first cycle after rst_l returns to 1.

Verification
REQ-035 WIDTH=32, STAGES=3: MULHU with a=b=0xFFFFFFFF, tag 7 -> 3 cycles later out_valid=1, out_result=0xFFFFFFFE, out_tag=7; MUL with the same operands -> 0x00000001.
REQ-036 MULH with signed a=0xFFFFFFFF and b=0x00000002 -> out_result=0xFFFFFFFF; MULHSU with a=0x80000000 (signed) and b=0xFFFFFFFF -> 0x80000000.
REQ-037 Four back-to-back ops with tags 1-4 and in_byp_b=1 on op 2 (byp_data=3, a=5, low) -> four consecutive out_valid cycles in order, op 2 result 15.
REQ-038 Two ops in flight, stall held 3 cycles -> outputs frozen, no op lost or duplicated, completion delayed by exactly 3 cycles.
REQ-039 flush together with in_valid while 2 ops are in flight -> busy=0 next cycle and no out_valid for any of the 3 ops.
REQ-040 rst_l pulsed low for 1 cycle with the pipe full -> out_valid=0 next cycle; an op issued the cycle after release returns after STAGES cycles; repeat for WIDTH=64, STAGES=2 and 4.
